// File: rtl/smart_led_rx_frame_ctrl.sv
// Receive-side frame controller behind the Manchester decoder: assembles MSB-first pixel
// words, tracks decoder lock, detects the latch gap and flags own-vs-forwarded frames.
module smart_led_rx_frame_ctrl #(
  parameter int FRAME_BITS  = 24,
  parameter int IDLE_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_data,
  input  logic                  dec_clk,
  input  logic                  dec_error,
  input  logic                  out_ready,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_first,
  output logic                  fwd_en,
  output logic                  latch,
  output logic                  locked,
  output logic                  overrun,
  output logic [7:0]            err_cnt
);

  localparam int CNT_W = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {HUNT, IDLE, RECV} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [7:0]            idle_cnt_reg, idle_cnt_next;
  logic [FRAME_BITS-1:0] shreg_reg, shreg_next;
  logic [FRAME_BITS-1:0] frame_data_reg, frame_data_next;
  logic                  frame_valid_reg, frame_valid_next;
  logic                  frame_first_reg, frame_first_next;
  logic                  fwd_en_reg, fwd_en_next;
  logic                  latch_reg, latch_next;
  logic                  overrun_reg, overrun_next;
  logic [7:0]            err_cnt_reg, err_cnt_next;

  logic                  frame_done;
  logic                  buf_free;
  logic                  idle_hit;
  logic [FRAME_BITS-1:0] word;

  assign word       = {shreg_reg[FRAME_BITS-2:0], dec_data};
  assign frame_done = (bit_cnt_reg == CNT_W'(FRAME_BITS - 1));
  // The consumer may drain the buffer on the very edge a new word lands.
  assign buf_free   = !frame_valid_reg || out_ready;
  assign idle_hit   = (idle_cnt_reg == 8'(IDLE_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= HUNT;
      bit_cnt_reg     <= '0;
      idle_cnt_reg    <= '0;
      shreg_reg       <= '0;
      frame_data_reg  <= '0;
      frame_valid_reg <= 1'b0;
      frame_first_reg <= 1'b0;
      fwd_en_reg      <= 1'b0;
      latch_reg       <= 1'b0;
      overrun_reg     <= 1'b0;
      err_cnt_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      idle_cnt_reg    <= idle_cnt_next;
      shreg_reg       <= shreg_next;
      frame_data_reg  <= frame_data_next;
      frame_valid_reg <= frame_valid_next;
      frame_first_reg <= frame_first_next;
      fwd_en_reg      <= fwd_en_next;
      latch_reg       <= latch_next;
      overrun_reg     <= overrun_next;
      err_cnt_reg     <= err_cnt_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    idle_cnt_next    = idle_cnt_reg;
    shreg_next       = shreg_reg;
    frame_data_next  = frame_data_reg;
    frame_valid_next = frame_valid_reg;
    frame_first_next = frame_first_reg;
    fwd_en_next      = fwd_en_reg;
    latch_next       = 1'b0;
    overrun_next     = overrun_reg;
    err_cnt_next     = err_cnt_reg;

    if (frame_valid_reg && out_ready) begin
      frame_valid_next = 1'b0;
    end

    if (dec_error) begin
      // Error wins over a coincident strobe; the partial word is abandoned.
      bit_cnt_next  = '0;
      idle_cnt_next = '0;
      if (state_reg != HUNT) begin
        state_next = HUNT;
        if (err_cnt_reg != 8'hFF) begin
          err_cnt_next = err_cnt_reg + 8'd1;
        end
      end
    end else if (dec_clk) begin
      state_next    = RECV;
      shreg_next    = word;
      idle_cnt_next = '0;
      if (frame_done) begin
        bit_cnt_next = '0;
        fwd_en_next  = 1'b1;
        if (buf_free) begin
          frame_data_next  = word;
          frame_valid_next = 1'b1;
          frame_first_next = ~fwd_en_reg;
        end else begin
          overrun_next = 1'b1;
        end
      end else begin
        bit_cnt_next = bit_cnt_reg + 1'b1;
      end
    end else if (state_reg == RECV) begin
      if (idle_hit) begin
        latch_next    = 1'b1;
        state_next    = IDLE;
        bit_cnt_next  = '0;
        idle_cnt_next = '0;
        fwd_en_next   = 1'b0;
        overrun_next  = 1'b0;
      end else if (idle_cnt_reg != 8'(IDLE_CYCLES)) begin
        idle_cnt_next = idle_cnt_reg + 8'd1;
      end
    end else begin
      idle_cnt_next = '0;
    end
  end

  assign frame_data  = frame_data_reg;
  assign frame_valid = frame_valid_reg;
  assign frame_first = frame_first_reg;
  assign fwd_en      = fwd_en_reg;
  assign latch       = latch_reg;
  assign locked      = (state_reg != HUNT);
  assign overrun     = overrun_reg;
  assign err_cnt     = err_cnt_reg;

endmodule

// File: doc/smart_led_rx_frame_ctrl.md
# smart_led_rx_frame_ctrl

Frame-level receive controller placed directly behind the Manchester decoder in the smart-LED data path. It consumes the decoder's bit strobe, data and error flags, and assembles FRAME_BITS-bit pixel words MSB first. It tracks lock state and detects the end-of-transfer latch gap. It also tells the downstream stage whether the current frame is this LED's own frame or one that must be forwarded along the chain.

## Interface
- FRAME_BITS, 24: bits per pixel frame; legal range 2..32.
- IDLE_CYCLES, 64: number of clk cycles without a bit strobe that ends a transfer (latch); legal range 2..255.
- clk  in  1  global clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- dec_data  in  1  decoded bit; valid only when dec_clk=1.
- dec_clk  in  1  one-cycle bit strobe from the decoder.
- dec_error  in  1  decoder not synchronised or invalid pulse.
- out_ready  in  1  downstream accepts frame_data when frame_valid=1.
- frame_data  out  FRAME_BITS  last completed frame, MSB = first received bit.
- frame_valid  out  1  frame_data holds an unconsumed frame.
- frame_first  out  1  frame_data is the first frame since the last latch or reset, i.e. this LED's own frame.
- fwd_en  out  1  the own frame has been taken; later bits belong to downstream LEDs.
- latch  out  1  one-cycle pulse at the end of a transfer.
- locked  out  1  state is not HUNT.
- overrun  out  1  sticky flag: a completed frame was dropped because the buffer was full.
- err_cnt  out  8  saturating count of lock losses.

## Operation
- States:
  - HUNT: reset state; waits for synchronisation.
  - IDLE: locked, no bits received since the last latch.
  - RECV: accumulating bits.
- HUNT -> RECV on dec_clk=1 with dec_error=0. That bit is the first bit of a frame.
- IDLE -> RECV on dec_clk=1 with dec_error=0.
- RECV -> IDLE on latch.
- IDLE or RECV -> HUNT on dec_error=1. Entering HUNT from RECV or IDLE increments err_cnt, saturating at 255.
- dec_error=1 always dominates: a dec_clk in the same cycle is ignored, bit_cnt is cleared and partial bits are discarded.
- Bit capture, for an accepted strobe (dec_clk=1, dec_error=0):
  - shreg <= {shreg[FRAME_BITS-2:0], dec_data}.
  - bit_cnt increments.
  - On the FRAME_BITS-th bit, the frame completes and bit_cnt returns to 0.
- Frame completion:
  - Buffer free when frame_valid=0, or when frame_valid=1 and out_ready=1 in the same cycle. In that case: frame_data <= completed word, frame_valid <= 1, frame_first <= ~fwd_en, fwd_en <= 1.
  - Buffer full otherwise: the frame is dropped, overrun <= 1, and frame_data, frame_valid and frame_first are unchanged. fwd_en <= 1 is still set so forwarding order is preserved.
- Handshake:
  - A frame transfers on a cycle with frame_valid=1 and out_ready=1.
  - frame_valid clears the following cycle unless a new frame completes in that same cycle.
- Idle counter:
  - Cleared on every accepted strobe; otherwise increments, saturating at IDLE_CYCLES.
  - Counts only in RECV; held at 0 in HUNT and IDLE.
- Latch: when the counter reaches IDLE_CYCLES in RECV, latch=1 for exactly one cycle. Same edge:
  - state <= IDLE, bit_cnt <= 0 (partial frame discarded).
  - fwd_en <= 0, overrun <= 0.
  - frame_valid and frame_data are untouched, so a pending frame remains deliverable.
- No latch is ever generated in HUNT or IDLE, so repeated gaps produce a single pulse.

## Timing
- Reset values: frame_data=0, frame_valid=0, frame_first=0, fwd_en=0, latch=0, locked=0, overrun=0, err_cnt=0, state=HUNT, bit_cnt=0, idle counter=0.
- All outputs are registered; no combinational input-to-output paths.
- Frame latency: frame_valid=1 in the cycle after the edge that samples the FRAME_BITS-th strobe.
- Latch: with the last strobe sampled at edge E0, latch is sampled high at edge E(IDLE_CYCLES) and is low again after the next edge.
- locked deasserts one cycle after dec_error is sampled high.
- Reset asserted mid-frame clears everything immediately, asynchronously. The first post-reset frame has frame_first=1.
- A latch and a frame completion cannot coincide, because a strobe clears the idle counter.

## Test plan
- Reset, then dec_error=0 and 24 strobes carrying 0xA5C3F0 -> frame_data=0xA5C3F0, frame_valid=1, frame_first=1, fwd_en=1, one cycle after strobe 24.
- Same frame with out_ready=1, then a second frame 0x123456 -> second frame has frame_first=0; after 64 idle cycles, latch pulses once, fwd_en=0, state IDLE. A third frame then has frame_first=1.
- out_ready=0 while two frames arrive -> first frame is held, second is dropped, overrun=1. overrun clears at the next latch.
- dec_error pulse after 10 bits, then 24 valid bits 0x00FF00 -> err_cnt=1, partial frame discarded, frame_data=0x00FF00.
- dec_clk and dec_error high in the same cycle -> bit ignored and err_cnt increments. 300 lock losses -> err_cnt saturates at 255.
- rst asserted asynchronously mid-frame (bit 12) -> all outputs at reset values without waiting for a clk edge. A later 100-cycle idle in HUNT produces no latch.
